// File: rtl/xalulite_win_pkg.sv
// Shared function codes and helpers for the windowed lite ALU (xalulite_win).
package xalulite_win_pkg;

   localparam int ALULITE_FNS_W = 4;

   typedef enum logic [ALULITE_FNS_W-1:0] {
      ALULITE_OR       = 4'd0,
      ALULITE_AND      = 4'd1,
      ALULITE_CMP_SIG  = 4'd2,
      ALULITE_MUX      = 4'd3,
      ALULITE_SUB      = 4'd4,
      ALULITE_ADD      = 4'd5,
      ALULITE_MAX      = 4'd6,
      ALULITE_MIN      = 4'd7,
      ALULITE_ABS_DIFF = 4'd8
   } alulite_fns_e;

   // Functions whose self-loop accumulation is seeded from operand B on a window's first sample.
   function automatic logic loads_first(input alulite_fns_e f);
      return f inside {ALULITE_ADD, ALULITE_OR, ALULITE_AND, ALULITE_MAX, ALULITE_MIN};
   endfunction

endpackage

// File: rtl/xalulite_win_addsub.sv
// DATA_W+1-bit signed adder/subtractor shared by the xalulite_win arithmetic functions.
// Saturating result when XALULITE_WIN_SAT_EN is defined, wrap-around otherwise.
module xalulite_addsub #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              sub,
   output logic [DATA_W:0]   wide,
   output logic [DATA_W-1:0] sum,
   output logic              sign,
   output logic              ovf
);

   logic [DATA_W:0] ax;
   logic [DATA_W:0] bx;

   assign ax   = {a[DATA_W-1], a};
   assign bx   = {b[DATA_W-1], b};
   // sub computes b - a, matching SUB/CMP_SIG operand order
   assign wide = sub ? (bx - ax) : (ax + bx);
   assign sign = wide[DATA_W];
   assign ovf  = wide[DATA_W] ^ wide[DATA_W-1];

`ifdef XALULITE_WIN_SAT_EN
   always_comb begin
      sum = wide[DATA_W-1:0];
      if (ovf)
         sum = sign ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
   end
`else
   assign sum = wide[DATA_W-1:0];
`endif

endmodule

// File: rtl/xalulite_win.sv
// Two-stage windowed lite ALU with self-loop accumulator restarting every `period` samples.
// Optional saturation of ADD/SUB/ABS_DIFF with XALULITE_WIN_SAT_EN.
module xalulite_win
   import xalulite_win_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     run,
   input  logic                     en,
   input  logic [DATA_W-1:0]        in1,
   input  logic [DATA_W-1:0]        in2,
   output logic [DATA_W-1:0]        out,
   output logic                     out_valid,
   output logic                     out_last,
   input  logic                     self_loop,
   input  logic [ALULITE_FNS_W-1:0] fns,
   input  logic [CNT_W-1:0]         period
);

   localparam logic [DATA_W-1:0] ONE  = DATA_W'(1);
   localparam logic [DATA_W-1:0] MAXP = {1'b0, {(DATA_W-1){1'b1}}};

   logic [DATA_W-1:0] in1_r;
   logic [DATA_W-1:0] in2_r;
   logic              en_r;
   logic              first_r;

   logic [CNT_W-1:0]  cnt;
   logic              pend;

   alulite_fns_e      fn;
   logic              first_eff;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W:0]   wide;
   logic [DATA_W-1:0] sum;
   logic              sign;
   logic              ovf_unused;
   logic [DATA_W-1:0] abs_v;
   logic [DATA_W-1:0] res;
   logic [CNT_W-1:0]  cnt_base;
   logic [CNT_W-1:0]  cnt_inc;
   logic              win_end;

   always_ff @(posedge clk) begin
      if (rst) begin
         in1_r   <= '0;
         in2_r   <= '0;
         en_r    <= 1'b0;
         first_r <= 1'b0;
      end else begin
         in1_r   <= in1;
         in2_r   <= in2;
         en_r    <= en;
         first_r <= run;
      end
   end

   // first_r carries the run pulse; pend carries window-close restarts decided in stage 2,
   // so a sample already in stage 1 when the window closes is still seen as first.
   assign first_eff = first_r | pend;
   assign fn        = alulite_fns_e'(fns);
   assign op_a      = self_loop ? out : in1_r;

   xalulite_addsub #(.DATA_W(DATA_W)) u_addsub (
      .a    (op_a),
      .b    (in2_r),
      .sub  (fn != ALULITE_ADD),
      .wide (wide),
      .sum  (sum),
      .sign (sign),
      .ovf  (ovf_unused)
   );

   assign abs_v = sign ? (~wide[DATA_W-1:0] + ONE) : wide[DATA_W-1:0];

   always_comb begin
      res = '0;
      case (fn)
         ALULITE_OR:      res = op_a | in2_r;
         ALULITE_AND:     res = op_a & in2_r;
         ALULITE_ADD:     res = sum;
         ALULITE_SUB:     res = sum;
         ALULITE_MAX:     res = sign ? op_a : in2_r;
         ALULITE_MIN:     res = sign ? in2_r : op_a;
         ALULITE_MUX:     res = in1_r[DATA_W-1] ? in2_r : (self_loop ? out : '0);
         ALULITE_CMP_SIG: res = {sign, wide[DATA_W-2:0]};
`ifdef XALULITE_WIN_SAT_EN
         ALULITE_ABS_DIFF: res = abs_v[DATA_W-1] ? MAXP : abs_v;
`else
         ALULITE_ABS_DIFF: res = abs_v;
`endif
         default:         res = '0;
      endcase
      if (self_loop && first_eff && loads_first(fn))
         res = in2_r;
   end

   always_comb begin
      cnt_base = first_eff ? '0 : cnt;
      cnt_inc  = cnt_base + CNT_W'(1);
      win_end  = (period != '0) && (cnt_inc == period);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out       <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         cnt       <= '0;
         pend      <= 1'b1;
      end else begin
         out_valid <= en_r;
         out_last  <= en_r & win_end;
         if (en_r) begin
            out  <= res;
            cnt  <= win_end ? '0 : cnt_inc;
            pend <= win_end;
         end else if (first_r) begin
            cnt  <= '0;
            pend <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_xalulite_win.sv
// Randomized self-checking bench for xalulite_win against an in-order sample-level model.
module tb_xalulite_win;
   import xalulite_win_pkg::*;

   localparam int    NE   = 8192;
   localparam longint MAXP = 2147483647;
   localparam longint MINN = -MAXP - 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic        en = 1'b0;
   logic [31:0] in1 = '0;
   logic [31:0] in2 = '0;
   logic [31:0] out;
   logic        out_valid;
   logic        out_last;
   logic        self_loop = 1'b0;
   logic [3:0]  fns = 4'd5;
   logic [15:0] period = '0;

   xalulite_win #(.DATA_W(32), .CNT_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .en        (en),
      .in1       (in1),
      .in2       (in2),
      .out       (out),
      .out_valid (out_valid),
      .out_last  (out_last),
      .self_loop (self_loop),
      .fns       (fns),
      .period    (period)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail = 0;
   int unsigned e_now = 0;

   bit          exp_v [NE];
   bit          exp_l [NE];
   bit          exp_r [NE];
   logic [31:0] exp_o [NE];
   logic [31:0] hold_out = '0;

   logic [31:0] m_out = '0;
   int unsigned m_cnt = 0;
   bit          m_pend = 1'b1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_checks++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s edge=%0d got=%h expected=%h", tag, e_now, got, expv);
      end
   endtask

   function automatic logic [31:0] fit(input longint r);
`ifdef XALULITE_WIN_SAT_EN
      if (r > MAXP) return 32'h7FFFFFFF;
      if (r < MINN) return 32'h80000000;
`endif
      return r[31:0];
   endfunction

   function automatic logic [31:0] ref_alu(input logic [3:0] f, input bit sl, input bit first,
                                           input logic [31:0] i1, input logic [31:0] i2,
                                           input logic [31:0] o);
      logic [31:0] av;
      longint      a, b, r;
      av = sl ? o : i1;
      a  = $signed(av);
      b  = $signed(i2);
      if (first && sl && (f == ALULITE_ADD || f == ALULITE_OR || f == ALULITE_AND ||
                          f == ALULITE_MAX || f == ALULITE_MIN))
         return i2;
      case (f)
         ALULITE_OR:      return av | i2;
         ALULITE_AND:     return av & i2;
         ALULITE_ADD:     return fit(a + b);
         ALULITE_SUB:     return fit(b - a);
         ALULITE_MAX:     return (a > b) ? av : i2;
         ALULITE_MIN:     return (a < b) ? av : i2;
         ALULITE_MUX:     return i1[31] ? i2 : (sl ? o : 32'h0);
         ALULITE_CMP_SIG: begin
            r = b - a;
            return {(a > b), r[30:0]};
         end
         ALULITE_ABS_DIFF: begin
            r = a - b;
            if (r < 0) r = -r;
`ifdef XALULITE_WIN_SAT_EN
            if (r > MAXP) r = MAXP;
`endif
            return r[31:0];
         end
         default:         return 32'h0;
      endcase
   endfunction

   // Inputs driven now are captured at edge e_now+1 and show up on out at edge e_now+2.
   task automatic model_apply(input bit r, input bit rn, input bit v,
                              input logic [31:0] a, input logic [31:0] b);
      int unsigned k;
      bit          first, last;
      logic [31:0] res;
      k = e_now;
      if (k + 2 >= NE) begin
         $display("FAIL cycle_budget edge=%0d got=%0d expected<%0d", k, k + 2, NE);
         $fatal(1, "cycle budget exceeded");
      end
      exp_v[k+2] = 1'b0;
      exp_l[k+2] = 1'b0;
      if (r) begin
         exp_r[k+1] = 1'b1;
         exp_v[k+1] = 1'b0;
         exp_l[k+1] = 1'b0;
         m_out  = '0;
         m_cnt  = 0;
         m_pend = 1'b1;
         return;
      end
      if (rn) begin
         m_cnt  = 0;
         m_pend = 1'b1;
      end
      if (v) begin
         first  = m_pend;
         res    = ref_alu(fns, self_loop, first, a, b, m_out);
         m_out  = res;
         m_cnt  = (m_cnt + 1) % 65536;
         last   = (period != 0) && (m_cnt == period);
         if (last) m_cnt = 0;
         m_pend = last;
         exp_v[k+2] = 1'b1;
         exp_l[k+2] = last;
         exp_o[k+2] = res;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      e_now++;
      #1;
      if (exp_r[e_now]) hold_out = '0;
      else if (exp_v[e_now]) hold_out = exp_o[e_now];
      check("out", out, hold_out);
      check("out_valid", {31'b0, out_valid}, {31'b0, exp_v[e_now]});
      check("out_last", {31'b0, out_last}, {31'b0, exp_l[e_now]});
   endtask

   task automatic drive(input bit r, input bit rn, input bit v,
                        input logic [31:0] a, input logic [31:0] b);
      rst = r; run = rn; en = v; in1 = a; in2 = b;
      model_apply(r, rn, v, a, b);
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, $urandom, $urandom);
   endtask

   task automatic set_cfg(input logic [3:0] f, input bit sl, input logic [15:0] p);
      idle(2);
      fns = f; self_loop = sl; period = p;
   endtask

   function automatic logic [31:0] rnd_data();
      case ($urandom_range(0, 5))
         0:       return 32'h7FFFFFFF;
         1:       return 32'h80000000;
         2:       return 32'($urandom_range(0, 20));
         3:       return -32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      check("reset_out", out, 32'h0);

      // pipeline with a bubble
      set_cfg(ALULITE_ADD, 1'b0, 16'd0);
      drive(1'b0, 1'b0, 1'b1, 32'd3, 32'd4);
      idle(1);
      drive(1'b0, 1'b0, 1'b1, 32'd10, 32'hFFFFFFFE);
      idle(2);
      check("pipe_final", out, 32'd8);

      // window of 3 with self-loop
      set_cfg(ALULITE_ADD, 1'b1, 16'd3);
      drive(1'b0, 1'b1, 1'b0, '0, '0);
      for (int i = 1; i <= 6; i++) drive(1'b0, 1'b0, 1'b1, $urandom, 32'(i));
      idle(2);
      check("win_final", out, 32'd15);

      // running signed max, never-closing window
      set_cfg(ALULITE_MAX, 1'b1, 16'd0);
      drive(1'b0, 1'b1, 1'b1, $urandom, -32'sd5);
      drive(1'b0, 1'b0, 1'b1, $urandom, 32'd7);
      drive(1'b0, 1'b0, 1'b1, $urandom, 32'd2);
      drive(1'b0, 1'b0, 1'b1, $urandom, -32'sd9);
      idle(2);
      check("max_final", out, 32'd7);

      // run mid-window discards the partial window
      set_cfg(ALULITE_ADD, 1'b1, 16'd4);
      drive(1'b0, 1'b1, 1'b0, '0, '0);
      drive(1'b0, 1'b0, 1'b1, $urandom, 32'd2);
      drive(1'b0, 1'b0, 1'b1, $urandom, 32'd3);
      drive(1'b0, 1'b1, 1'b1, $urandom, 32'd100);
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, $urandom, 32'd1);
      idle(2);
      check("rerun_final", out, 32'd103);

      // overflow boundaries
      set_cfg(ALULITE_ADD, 1'b0, 16'd0);
      drive(1'b0, 1'b0, 1'b1, 32'h7FFFFFF0, 32'h20);
      idle(2);
`ifdef XALULITE_WIN_SAT_EN
      check("add_ovf", out, 32'h7FFFFFFF);
`else
      check("add_ovf", out, 32'h80000010);
`endif
      set_cfg(ALULITE_ABS_DIFF, 1'b0, 16'd0);
      drive(1'b0, 1'b0, 1'b1, 32'h80000000, 32'h1);
      idle(2);
`ifdef XALULITE_WIN_SAT_EN
      check("abs_ovf", out, 32'h7FFFFFFF);
`else
      check("abs_ovf", out, 32'h80000001);
`endif

      // reset with two samples in flight
      set_cfg(ALULITE_ADD, 1'b0, 16'd1);
      drive(1'b0, 1'b0, 1'b1, 32'd5, 32'd6);
      idle(2);
      drive(1'b0, 1'b0, 1'b1, 32'd1, 32'd2);
      drive(1'b1, 1'b0, 1'b1, 32'd3, 32'd4);
      check("rst_flush", out, 32'h0);
      idle(3);

      // randomized configurations and traffic
      for (int blk = 0; blk < 40; blk++) begin
         set_cfg(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 16'($urandom_range(0, 5)));
         drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), rnd_data(), rnd_data());
         for (int i = 0; i < 50; i++)
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 4,
                  $urandom_range(0, 99) < 70, rnd_data(), rnd_data());
      end
      idle(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
